// File: rtl/state_dump_unit.sv
// state_dump_unit: halts the core and streams header, register file, then data memory over valid/ready
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   dump request, honoured only when idle
//   cpu_halt    out  freezes the core while a dump is in progress
//   reg_rd_addr out  register-file read address, reg_rd_data returns same cycle
//   mem_rd_addr out  data-memory read address, mem_rd_data returns same cycle
//   out_valid/out_ready/out_data/out_last  word stream towards the capture bridge
//   busy        out  any state other than idle
//   done        out  one-cycle pulse after the last word is accepted
module state_dump_unit #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8,
  parameter logic [DATA_W-1:0] HEADER = 16'hA5A5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              cpu_halt,
  output logic [REG_AW-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic [MEM_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, HALT, HDR, REGS, MEM, FIN} state_t;
  state_t state, state_nx;
  logic [REG_AW-1:0] reg_cnt;
  logic [MEM_AW-1:0] mem_cnt;
  logic load_en;
  assign busy = state != IDLE;
  assign cpu_halt = busy;
  assign done = state == FIN;
  assign reg_rd_addr = (state == HDR || state == REGS) ? reg_cnt : '0;
  assign mem_rd_addr = state == MEM ? mem_cnt : '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    load_en = !out_valid || out_ready;
    state_nx = state;
    case (state)
      IDLE:      state_nx = start ? HALT : IDLE;
      HALT:      state_nx = HDR;
      HDR, REGS: state_nx = !load_en ? state : (&reg_cnt ? MEM : REGS);
      MEM:       state_nx = (load_en && out_last) ? FIN : MEM;
      FIN:       state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  // out_last only rises on the final memory word, so a load_en while it is set is the final accept
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      reg_cnt <= '0;
      mem_cnt <= '0;
    end else begin
      case (state)
        HALT: begin
          out_data <= HEADER;
          out_valid <= 1'b1;
          out_last <= 1'b0;
        end
        HDR, REGS: if (load_en) begin
          out_data <= reg_rd_data;
          reg_cnt <= reg_cnt + REG_AW'(1);
        end
        MEM: if (load_en) begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
          end else begin
            out_data <= mem_rd_data;
            out_last <= &mem_cnt;
            mem_cnt <= mem_cnt + MEM_AW'(1);
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_state_dump_unit.sv
// tb_state_dump_unit: directed frame checks for state_dump_unit with a tiny halting core model
module tb_state_dump_unit;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic cpu_halt, out_valid, out_last, busy, done;
  logic [3:0] reg_rd_addr;
  logic [7:0] mem_rd_addr;
  logic [15:0] reg_rd_data, mem_rd_data, out_data;
  logic [15:0] regs [16];
  logic [15:0] core_regs [16];
  logic [15:0] mem [256];
  logic core_en = 1'b0;
  logic [7:0] pc = 8'd0;
  int n_checks = 0, n_fail = 0;

  state_dump_unit dut (
    .clock(clock), .reset(reset), .start(start), .cpu_halt(cpu_halt),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  assign reg_rd_data = core_en ? core_regs[reg_rd_addr] : regs[reg_rd_addr];
  assign mem_rd_data = mem[mem_rd_addr];

  // core stand-in: each unhalted cycle executes an sll writing pc<<1 to r[pc%16]
  always @(posedge clock)
    if (core_en && !cpu_halt) begin
      core_regs[pc[3:0]] = {7'b0, pc, 1'b0};
      pc = pc + 8'd1;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_dump(input string nm, input bit toggle, input int restart_at, input int abort_at);
    logic [15:0] exp[$];
    logic [15:0] got[$];
    bit lst[$];
    int done_cnt = 0, done_cyc = -1, first_cyc = -1, n_last = 0;
    bit held = 1'b0;
    logic [15:0] hold_d = '0;
    logic [7:0] pc_h;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({nm, ":busy"}, 32'(busy), 32'd1);
    check({nm, ":halt"}, 32'(cpu_halt), 32'd1);
    exp.push_back(16'hA5A5);
    for (int i = 0; i < 16; i++) exp.push_back(core_en ? core_regs[i] : regs[i]);
    for (int k = 0; k < 256; k++) exp.push_back(mem[k]);
    pc_h = pc;
    for (int cyc = 0; cyc < 1500 && !(done_cnt > 0 && cyc > done_cyc + 20); cyc++) begin
      if (abort_at >= 0 && got.size() == abort_at) begin
        start = 1'b0;
        reset = 1'b1;
        #1;
        check({nm, ":abort_halt"}, 32'(cpu_halt), 32'd0);
        check({nm, ":abort_valid"}, 32'(out_valid), 32'd0);
        check({nm, ":abort_busy"}, 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check({nm, ":abort_idle"}, 32'(busy), 32'd0);
        return;
      end
      out_ready = toggle ? cyc[0] : 1'b1;
      start = done ? 1'b1 : (got.size() == restart_at);
      if (done) begin
        if (done_cnt == 0) done_cyc = cyc;
        done_cnt++;
        if (core_en) check({nm, ":pc_frozen"}, 32'(pc), 32'(pc_h));
      end
      if (held) check({nm, ":hold"}, {15'b0, out_valid, out_data}, {15'b0, 1'b1, hold_d});
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      held = out_valid && !out_ready;
      hold_d = out_data;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        lst.push_back(out_last);
      end
      @(negedge clock);
    end
    start = 1'b0;
    check({nm, ":words"}, 32'(got.size()), 32'd273);
    check({nm, ":done_cnt"}, 32'(done_cnt), 32'd1);
    if (!toggle) begin
      check({nm, ":first_cyc"}, 32'(first_cyc), 32'd1);
      check({nm, ":done_cyc"}, 32'(done_cyc), 32'd274);
    end
    for (int i = 0; i < got.size() && i < 273; i++) begin
      check($sformatf("%s:w%0d", nm, i), 32'(got[i]), 32'(exp[i]));
      n_last += int'(lst[i]);
    end
    check({nm, ":n_last"}, 32'(n_last), 32'd1);
    if (got.size() >= 273) check({nm, ":last_flag"}, 32'(lst[272]), 32'd1);
  endtask

  initial begin
    logic [7:0] pc_a;
    for (int i = 0; i < 16; i++) regs[i] = 16'(i * 3);
    for (int k = 0; k < 256; k++) mem[k] = 16'(k * 7 + 1);
    repeat (2) @(negedge clock);
    check("rst:halt", 32'(cpu_halt), 32'd0);
    check("rst:valid", 32'(out_valid), 32'd0);
    check("rst:last", 32'(out_last), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:data", 32'(out_data), 32'd0);
    check("rst:raddr", 32'(reg_rd_addr), 32'd0);
    check("rst:maddr", 32'(mem_rd_addr), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    run_dump("t1", 1'b0, -1, -1);
    run_dump("t2", 1'b1, -1, -1);
    for (int k = 0; k < 256; k++) mem[k] = ~16'(k);
    run_dump("t3", 1'b0, -1, -1);
    run_dump("t4", 1'b0, 5, -1);
    run_dump("t5", 1'b0, -1, 100);
    run_dump("t5b", 1'b0, -1, -1);
    core_en = 1'b1;
    repeat (40) @(negedge clock);
    run_dump("t6", 1'b0, -1, -1);
    pc_a = pc;
    repeat (3) @(negedge clock);
    check("t6:resume", 32'(pc - pc_a), 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
